// File: rtl/approx_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : approx_mult_pkg
// Purpose  : Shared helpers for the approximate multiplier pipeline.
//            - keep_pp    : static keep/drop decision for partial product (i,j)
//            - prod_width : product width for a given operand width
//            - sum_width  : error-accumulator width for a given operand width
//            - sat_add    : unsigned add that clamps at all-ones of a given width
// Ports    : none (package)
// Revision : 1.0 - initial parametrised release
// ============================================================================
package approx_mult_pkg;

  // Headroom bits on the error accumulator above the product width.
  localparam int SUM_GUARD_W = 16;

  // Widest value sat_add can handle.
  localparam int SAT_MAX_W = 64;

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

  function automatic int sum_width(input int width);
    return 2 * width + SUM_GUARD_W;
  endfunction

  // Keep decision that ignores the runtime exact mode: the top EXACT_ROWS
  // rows are always whole, everything else survives only at or above the
  // truncation column.
  function automatic logic keep_pp(input int i, input int j, input int width,
                                   input int exact_rows, input int trunc_col);
    return ((i >= width - exact_rows) || (i + j >= trunc_col)) ? 1'b1 : 1'b0;
  endfunction

  // Operands are zero-extended into SAT_MAX_W bits; the result clamps at
  // 2^w - 1 so callers can truncate back to w bits without wrapping.
  function automatic logic [SAT_MAX_W-1:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                   input logic [SAT_MAX_W-1:0] b,
                                                   input int w);
    logic [SAT_MAX_W:0] full;
    logic [SAT_MAX_W:0] lim;
    full = {1'b0, a} + {1'b0, b};
    lim  = ({{SAT_MAX_W{1'b0}}, 1'b1} << w) - {{SAT_MAX_W{1'b0}}, 1'b1};
    return (full > lim) ? lim[SAT_MAX_W-1:0] : full[SAT_MAX_W-1:0];
  endfunction

endpackage : approx_mult_pkg
`default_nettype wire

// File: rtl/approx_pp_sum.sv
`default_nettype none
// ============================================================================
// Module   : approx_pp_sum
// Purpose  : Combinational split of the partial-product array into the sum of
//            kept terms and the sum of dropped terms. kept_sum + drop_sum is
//            always the exact product, so neither sum can overflow PROD_W.
// Ports    : x, y        - operands (x selects rows, y selects columns)
//            exact_mode  - 1 keeps every term (drop_sum becomes 0)
//            kept_sum    - approximate product
//            drop_sum    - exact product minus approximate product
// Revision : 1.0 - initial parametrised release
// ============================================================================
module approx_pp_sum
  import approx_mult_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EXACT_ROWS = 2,
  parameter int TRUNC_COL  = 7,
  localparam int PROD_W    = prod_width(WIDTH)
) (
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  input  logic              exact_mode,
  output logic [PROD_W-1:0] kept_sum,
  output logic [PROD_W-1:0] drop_sum
);

  logic [WIDTH-1:0][WIDTH-1:0]  w_keep_bits;
  logic [WIDTH-1:0][WIDTH-1:0]  w_drop_bits;
  logic [WIDTH-1:0][PROD_W-1:0] w_keep_row;
  logic [WIDTH-1:0][PROD_W-1:0] w_drop_row;

  genvar gi, gj;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_row
      for (gj = 0; gj < WIDTH; gj++) begin : g_col
        // The keep mask is fixed at elaboration; only exact_mode is dynamic.
        localparam logic KEEP = keep_pp(gi, gj, WIDTH, EXACT_ROWS, TRUNC_COL);
        logic w_pp;
        assign w_pp                = x[gi] & y[gj];
        assign w_keep_bits[gi][gj] = w_pp & (KEEP | exact_mode);
        assign w_drop_bits[gi][gj] = w_pp & ~(KEEP | exact_mode);
      end
      // Row gi carries weight 2^gi.
      assign w_keep_row[gi] = {{WIDTH{1'b0}}, w_keep_bits[gi]} << gi;
      assign w_drop_row[gi] = {{WIDTH{1'b0}}, w_drop_bits[gi]} << gi;
    end
  endgenerate

  always_comb begin
    kept_sum = '0;
    drop_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      kept_sum = kept_sum + w_keep_row[i];
      drop_sum = drop_sum + w_drop_row[i];
    end
  end

endmodule : approx_pp_sum
`default_nettype wire

// File: rtl/approx_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : approx_mult_pipe
// Purpose  : 3-stage valid/ready pipelined unsigned approximate multiplier
//            with per-transaction exact/approximate mode, per-result error
//            and saturating error statistics.
//              S1 - operand/mode capture
//              S2 - kept/dropped partial-product sums
//              S3 - result registers and statistics update
// Ports    : clk, rst_n                    - clock, async active-low reset
//            in_valid/in_ready, x, y,
//            exact_mode                    - operand handshake
//            out_valid/out_ready, z, err   - result handshake
//            stats_clr                     - clear statistics (wins over update)
//            txn_cnt, err_sum, err_max     - statistics (CNT_W <= 64)
// Revision : 1.0 - initial parametrised release
// ============================================================================
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EXACT_ROWS = 2,
  parameter int TRUNC_COL  = 7,
  parameter int CNT_W      = 32,
  localparam int PROD_W    = prod_width(WIDTH),
  localparam int SUM_W     = sum_width(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  input  logic              exact_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] z,
  output logic [PROD_W-1:0] err,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  txn_cnt,
  output logic [SUM_W-1:0]  err_sum,
  output logic [PROD_W-1:0] err_max
);

  logic              r_s1_valid;
  logic [WIDTH-1:0]  r_s1_x;
  logic [WIDTH-1:0]  r_s1_y;
  logic              r_s1_mode;
  logic              r_s2_valid;
  logic [PROD_W-1:0] r_s2_kept;
  logic [PROD_W-1:0] r_s2_drop;
  logic [PROD_W-1:0] w_kept;
  logic [PROD_W-1:0] w_drop;
  logic              w_s1_adv;
  logic              w_s2_adv;
  logic              w_s3_adv;
  logic              w_out_xfer;

  // Bubble-collapsing advance chain: a stage may load when it is empty or
  // its contents move on this edge. Only out_ready feeds back, never in_valid.
  assign w_s3_adv   = !out_valid || out_ready;
  assign w_s2_adv   = !r_s2_valid || w_s3_adv;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign in_ready   = w_s1_adv;
  assign w_out_xfer = out_valid && out_ready;

  // S1: capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_mode  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_x    <= x;
        r_s1_y    <= y;
        r_s1_mode <= exact_mode;
      end
    end
  end

  approx_pp_sum #(
    .WIDTH      (WIDTH),
    .EXACT_ROWS (EXACT_ROWS),
    .TRUNC_COL  (TRUNC_COL)
  ) u_pp_sum (
    .x          (r_s1_x),
    .y          (r_s1_y),
    .exact_mode (r_s1_mode),
    .kept_sum   (w_kept),
    .drop_sum   (w_drop)
  );

  // S2: partial-product sums
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_kept  <= '0;
      r_s2_drop  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_kept <= w_kept;
        r_s2_drop <= w_drop;
      end
    end
  end

  // S3: result registers; data only moves when a new result arrives so a
  // stalled result stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      z         <= '0;
      err       <= '0;
    end else if (w_s3_adv) begin
      out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        z   <= r_s2_kept;
        err <= r_s2_drop;
      end
    end
  end

  // Statistics track the result leaving S3; a clear on the same edge wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt <= '0;
      err_sum <= '0;
      err_max <= '0;
    end else if (stats_clr) begin
      txn_cnt <= '0;
      err_sum <= '0;
      err_max <= '0;
    end else if (w_out_xfer) begin
      txn_cnt <= CNT_W'(sat_add(64'(txn_cnt), 64'd1, CNT_W));
      err_sum <= SUM_W'(sat_add(64'(err_sum), 64'(err), SUM_W));
      if (err > err_max) begin
        err_max <= err;
      end
    end
  end

endmodule : approx_mult_pipe
`default_nettype wire

// File: doc/approx_mult_pipe.md
Name: approx_mult_pipe

Overview:
Parametrised pipelined unsigned approximate multiplier, the successor to the fixed 8x8 row-exchange/column-truncation multipliers.
- Approximation is generalised to any WIDTH, number of exact top rows and truncation column.
- Adds a runtime exact/approximate mode, a valid/ready pipeline, per-result error output and saturating error statistics.
- Sits between operand producers and accumulator datapaths in accuracy-exploration builds.

Parameters:
WIDTH, 8, operand width in bits (4..16)
EXACT_ROWS, 2, count of top multiplier rows x[WIDTH-1 -: EXACT_ROWS] always kept in full (0..WIDTH)
TRUNC_COL, 7, partial products of the remaining rows with column i+j < TRUNC_COL are dropped (0..2*WIDTH-1)
CNT_W, 32, width of the transaction counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
x  in  WIDTH  multiplier operand (rows)
y  in  WIDTH  multiplicand operand (columns)
exact_mode  in  1  1: full product for this transaction; 0: approximate; sampled with x/y
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
z  out  2*WIDTH  product (exact or approximate)
err  out  2*WIDTH  exact product minus z; 0 in exact mode
stats_clr  in  1  synchronous clear pulse for the statistics
txn_cnt  out  CNT_W  completed transactions, saturating
err_sum  out  2*WIDTH+16  accumulated err, saturating
err_max  out  2*WIDTH  largest err since clear

Behaviour:
- Reset (rst_n low, async): all stage valids 0, out_valid 0, z/err 0, txn_cnt/err_sum/err_max 0; in_ready goes to 1 on the first cycle after release.
- Approximate term set:
  - pp(i,j) = x[i]&y[j] at weight 2^(i+j).
  - pp(i,j) is kept iff i >= WIDTH-EXACT_ROWS, or i+j >= TRUNC_COL, or exact_mode=1.
  - z = sum of kept terms; the sum never exceeds x*y, so err = x*y - z >= 0. No wrap at 2*WIDTH bits.
- Pipeline: 3 register stages.
  - S1: operand/mode capture.
  - S2: kept-term and dropped-term row sums.
  - S3: z, err and stats update.
  - Latency is exactly 3 cycles from accepted input to out_valid when unstalled; throughput is 1 per cycle.
- Handshake:
  - Transfer occurs when valid&ready on a cycle edge.
  - Bubble-collapsing: stage k loads when it is empty or stage k+1 loads/drains.
  - in_ready = S1 empty or S1 advancing (combinational from out_ready allowed, no combinational in_valid->in_ready path).
  - With out_valid=1 and out_ready=0, z/err/out_valid hold stable; in_ready drops only once all 3 stages are full.
- Ordering: strict FIFO; no reordering and no drop.
- Statistics: updated on each output transfer (out_valid&out_ready).
  - txn_cnt += 1.
  - err_sum += err.
  - err_max = max(err_max, err).
  - txn_cnt and err_sum saturate at all-ones; they never wrap.
- stats_clr: zeroes txn_cnt, err_sum and err_max next cycle. If it coincides with an output transfer, the clear wins and that transaction is not counted. The pipeline contents are unaffected.
- Reset mid-operation: in-flight transactions are discarded with no output.
- exact_mode may change per transaction; each result uses its own sampled mode.

Decomposition:
- Package approx_mult_pkg:
  - function keep_pp(i, j, WIDTH, EXACT_ROWS, TRUNC_COL)
  - localparams PROD_W = 2*WIDTH and SUM_W = 2*WIDTH+16
  - saturating-add function
- One sub-module, approx_pp_sum: combinational kept/dropped partial-product summation for S2, parametrised like the top.

Test Plan:
- Default params, x=255, y=255, exact_mode=0 -> after 3 cycles z=64320, err=705; with exact_mode=1 -> z=65025, err=0.
- x=3, y=5, mode 0 -> z=0, err=15; x=128, y=1 -> z=128, err=0; x=2, y=64 -> z=128, err=0 (column 7 kept).
- Back-to-back stream of 10 pairs with out_ready held low from cycle 2 -> in_ready low after 3 accepts, outputs held stable; on release, all 10 results in order, no loss or duplication.
- Stats: send 255x255 (mode 0) then 3x5 -> txn_cnt=2, err_sum=720, err_max=705; stats_clr on the same cycle as a third transfer -> all stats 0 next cycle.
- Saturation: CNT_W=4 and 20 transfers -> txn_cnt stays 15.
- Async reset asserted with 3 transactions in flight -> out_valid=0 immediately, no stale output after release; sweep WIDTH=4/16 and EXACT_ROWS=WIDTH (err always 0) against a reference model on random operands.
